sram_word_ctrl: RTL
===================

# sram_word_ctrl

Host-side controller sitting directly upstream of the 512 KiB byte-wide SRAM. It accepts 32-bit word read/write requests over a valid/ready handshake and sequences each one into four byte accesses on the SRAM's chip-select/write-enable/address/data pins. It returns one response pulse per request: read data for reads, a write acknowledge for writes. It is the single master of the SRAM; arbitration between CPU and DMA happens upstream of this block.

## Interface
Parameters:
- WAIT_STATES, 0: extra cycles held per byte access (0..15); each byte lane occupies 1+WAIT_STATES cycles.

Ports:
- i_clk, in, 1: sole clock; all state changes on rising edge.
- i_reset, in, 1: reset, synchronous, active-high.
- i_req_valid, in, 1: request present.
- o_req_ready, out, 1: block can accept a request.
- i_req_we, in, 1: 1 = write, 0 = read.
- i_req_addr, in, 19: byte address; bits [1:0] ignored (word-aligned).
- i_req_wdata, in, 32: write data, little-endian.
- i_req_be, in, 4: write byte enables; ignored for reads.
- o_rsp_valid, out, 1: one-cycle response pulse; no backpressure.
- o_rsp_rdata, out, 32: read data; valid when o_rsp_valid follows a read.
- o_sram_cs_n, out, 1: SRAM chip select, active-low.
- o_sram_wr_n, out, 1: SRAM write enable, active-low.
- o_sram_addr, out, 19: SRAM byte address.
- o_sram_data, out, 8: SRAM write data.
- i_sram_data, in, 8: SRAM read data (combinational from o_sram_addr).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - o_req_ready=1, o_sram_cs_n=1, o_sram_wr_n=1, o_sram_addr=0, o_sram_data=0.
  - On i_req_valid&o_req_ready: latch we, addr[18:2], wdata, be; lane=0; wait counter=0; go to ACCESS.
- ACCESS:
  - o_req_ready=0; o_sram_addr={addr[18:2], lane}.
  - Read: cs_n=0, wr_n=1.
  - Write with be[lane]=1: cs_n=0, wr_n=0, o_sram_data=wdata[8*lane+:8].
  - Write with be[lane]=0: cs_n=1, wr_n=1; the slot is still consumed, so timing is independent of be.
  - Wait counter counts 0..WAIT_STATES. On the last cycle of a read lane, capture i_sram_data into rdata[8*lane+:8].
  - After lane 3's last cycle, go to RESP.
- RESP:
  - o_rsp_valid=1 for exactly one cycle; cs_n=1, wr_n=1, o_req_ready=0; then go to IDLE.
- o_rsp_rdata:
  - Updated only by reads; writes leave it unchanged.
  - Held stable until the next read completes.
- Byte order: lane n ↔ byte address {addr[18:2], n} ↔ data bits [8n+7:8n].
- Address wrap: none. The word address is used as-is; 0x7FFFC..0x7FFFF is the last word.

## Timing
- Request accepted at rising edge E. ACCESS occupies the next 4·(1+WAIT_STATES) cycles. o_rsp_valid is high in the cycle after that.
- WAIT_STATES=0: response 5 cycles after acceptance. Minimum request spacing is 6 cycles, because ready returns only in IDLE.
- A request held valid while ready=0 is not accepted and must be held by the host; valid need not be deasserted between requests.
- Byte writes: the SRAM writes on every rising edge while cs_n=0 and wr_n=0. With wait states, the same byte is rewritten each edge (harmless).
- Reset (sampled at a rising edge, any state):
  - Next cycle is IDLE with o_req_ready=1, o_rsp_valid=0, cs_n=1, wr_n=1, o_sram_addr=0, o_sram_data=0, o_rsp_rdata=0.
  - An aborted request produces no response. Bytes already written stay written; partial words are permitted.
- Reset values apply to all outputs while i_reset is high.

## Test plan
- Write then read, WAIT_STATES=0:
  - Write addr 0x00104, wdata 0xDEADBEEF, be 0xF → SRAM 0x104..0x107 = EF,BE,AD,DE; o_rsp_valid 5 cycles after accept.
  - Read addr 0x00104 → o_rsp_rdata=0xDEADBEEF.
- Partial write:
  - Preload word 0x00200 = 0x11223344.
  - Write 0xAABBCCDD with be 0x5 → read returns 0x11BB33DD; cs_n high in lanes 1 and 3; response timing identical to full write.
- WAIT_STATES=2:
  - Read 0x7FFFC (preloaded 0xCAFEF00D) → each lane holds cs_n=0 for 3 cycles with a constant address; o_rsp_valid 13 cycles after accept; rdata=0xCAFEF00D.
- Back-to-back:
  - i_req_valid held high with two reads queued → second accept exactly 6 cycles after the first (W=0); o_req_ready low between.
  - i_req_addr[1:0]=3 behaves as 0.
- Reset mid-write:
  - Assert i_reset during lane 2 of a be=0xF write of 0x01020304 to 0x00300 (prior contents 0xFFFFFFFF) → next cycle IDLE, no o_rsp_valid.
  - Subsequent read returns 0xFFFF0304.

Source files
------------

// File: rtl/sram_word_ctrl.sv
// rtl/sram_word_ctrl.sv - 32-bit word requests sequenced into four byte accesses on a byte-wide SRAM
//
// Ports:
//   i_clk           sole clock, rising edge
//   i_reset         synchronous active-high reset
//   i_req_valid     request present
//   o_req_ready     request can be accepted (IDLE only)
//   i_req_we        1 = write, 0 = read
//   i_req_addr      byte address, bits [1:0] ignored
//   i_req_wdata     write data, little-endian
//   i_req_be        write byte enables
//   o_rsp_valid     one-cycle response pulse per request
//   o_rsp_rdata     last completed read data
//   o_sram_cs_n     SRAM chip select, active-low
//   o_sram_wr_n     SRAM write enable, active-low
//   o_sram_addr     SRAM byte address
//   o_sram_data     SRAM write data
//   i_sram_data     SRAM read data, combinational from o_sram_addr

module sram_word_ctrl #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [18:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_sram_cs_n,
  output logic        o_sram_wr_n,
  output logic [18:0] o_sram_addr,
  output logic [7:0]  o_sram_data,
  input  logic [7:0]  i_sram_data
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_we;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [1:0]  r_lane;
  logic [3:0]  r_wait;
  logic [23:0] r_rd_buf;
  logic [31:0] r_rdata;

  logic        w_lane_last;
  logic        w_ready;
  logic        w_rsp_valid;
  logic        w_cs_n;
  logic        w_wr_n;
  logic [18:0] w_addr;
  logic [7:0]  w_data;
  logic        w_unused;

  // Word alignment: the low address bits are dropped on purpose.
  assign w_unused    = &{1'b0, i_req_addr[1:0]};

  assign w_lane_last = (r_wait == LP_WAIT);

  // Next-state and SRAM pin decode.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_rsp_valid  = 1'b0;
    w_cs_n       = 1'b1;
    w_wr_n       = 1'b1;
    w_addr       = 19'd0;
    w_data       = 8'd0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (i_req_valid) begin
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_addr = {r_word, r_lane};
        if (!r_we) begin
          w_cs_n = 1'b0;
        end else if (r_be[r_lane]) begin
          w_cs_n = 1'b0;
          w_wr_n = 1'b0;
          w_data = r_wdata[{r_lane, 3'b000} +: 8];
        end
        // Disabled write lanes still burn their slot so that
        // request latency never depends on the byte enables.
        if (w_lane_last && (r_lane == 2'd3)) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Outputs take their reset values for as long as reset is held,
  // so an interrupted byte write is dropped in the cycle reset rises.
  assign o_req_ready = i_reset ? 1'b1  : w_ready;
  assign o_rsp_valid = i_reset ? 1'b0  : w_rsp_valid;
  assign o_sram_cs_n = i_reset ? 1'b1  : w_cs_n;
  assign o_sram_wr_n = i_reset ? 1'b1  : w_wr_n;
  assign o_sram_addr = i_reset ? 19'd0 : w_addr;
  assign o_sram_data = i_reset ? 8'd0  : w_data;
  assign o_rsp_rdata = i_reset ? 32'd0 : r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_word   <= 17'd0;
      r_wdata  <= 32'd0;
      r_be     <= 4'd0;
      r_lane   <= 2'd0;
      r_wait   <= 4'd0;
      r_rd_buf <= 24'd0;
      r_rdata  <= 32'd0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we    <= i_req_we;
            r_word  <= i_req_addr[18:2];
            r_wdata <= i_req_wdata;
            r_be    <= i_req_be;
            r_lane  <= 2'd0;
            r_wait  <= 4'd0;
          end
        end
        S_ACCESS: begin
          if (w_lane_last) begin
            r_wait <= 4'd0;
            r_lane <= r_lane + 2'd1;
            if (!r_we) begin
              // Lanes 0..2 collect in a side buffer; the visible read
              // register changes only when the whole word is in, so it
              // stays stable between read completions.
              case (r_lane)
                2'd0:    r_rd_buf[7:0]   <= i_sram_data;
                2'd1:    r_rd_buf[15:8]  <= i_sram_data;
                2'd2:    r_rd_buf[23:16] <= i_sram_data;
                default: r_rdata         <= {i_sram_data, r_rd_buf};
              endcase
            end
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
